// File: rtl/bootram_arbiter_pkg.sv
// Shared constants and helpers for the boot ROM arbiter.
// Port index encoding and the ROM window address check.
package bootram_arbiter_pkg;

    localparam logic [31:0] BOOTROM_BASE  = 32'h0000_0000;
    localparam int unsigned BOOTROM_WORDS = 72;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
    } resp_slot_t;

    // Out-of-window, misaligned, or past the populated words.
    function automatic logic addr_bad(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [31:0] idx;
        idx = {25'd0, addr[8:2]};
        return (addr[31:9] != base[31:9])
            || (addr[1:0] != 2'b00)
            || (idx >= words);
    endfunction

endpackage

// File: rtl/bootram_arbiter_rr.sv
// Two-way round-robin grant with a last-grant register.
// Reusable in front of any shared single-port memory.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/bootram_arbiter.sv
// Shares the synchronous-read boot ROM between fetch and loader.
// One access per cycle; the word returns to its owner one cycle later.
module bootram_arbiter
    import bootram_arbiter_pkg::*;
#(
    parameter logic [31:0] BOOT_BASE = BOOTROM_BASE,
    parameter int unsigned ROM_WORDS = BOOTROM_WORDS,
    parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic [31:0] req_addr_0,
    output logic        req_ready_0,
    output logic        resp_valid_0,
    output logic [31:0] resp_data_0,
    output logic        resp_err_0,
    input  logic        req_valid_1,
    input  logic [31:0] req_addr_1,
    output logic        req_ready_1,
    output logic        resp_valid_1,
    output logic [31:0] resp_data_1,
    output logic        resp_err_1,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rd_data
);

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_rv;
    logic        w_rv0;
    logic        w_rv1;
    resp_slot_t  r_slot;

    // No grants while in reset: the slot would be discarded anyway.
    assign w_req = {req_valid_1, req_valid_0} & {2{~rst}};

    rr_arbiter2 u_rr (
        .i_clk (clk),
        .i_rst (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign req_ready_0 = w_gnt[PORT_FETCH];
    assign req_ready_1 = w_gnt[PORT_LOAD];

    assign w_addr   = w_gnt[PORT_LOAD] ? req_addr_1 : req_addr_0;
    assign rom_addr = w_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else begin
            r_slot.valid <= |w_gnt;
            r_slot.owner <= w_gnt[PORT_LOAD];
            r_slot.err   <= addr_bad(w_addr, BOOT_BASE, ROM_WORDS);
        end
    end

    // A response due while reset is asserted is dropped.
    assign w_rv   = r_slot.valid & ~rst;
    assign w_rv0  = w_rv & (r_slot.owner == PORT_FETCH);
    assign w_rv1  = w_rv & (r_slot.owner == PORT_LOAD);
    assign w_data = r_slot.err ? ERR_DATA : rom_rd_data;

    assign resp_valid_0 = w_rv0;
    assign resp_data_0  = w_rv0 ? w_data : 32'd0;
    assign resp_err_0   = w_rv0 & r_slot.err;

    assign resp_valid_1 = w_rv1;
    assign resp_data_1  = w_rv1 ? w_data : 32'd0;
    assign resp_err_1   = w_rv1 & r_slot.err;

endmodule
